// File: rtl/uart_cmd_responder_if.sv
// ============================================================================
//  Module      : uart_cmd_responder_if
//  Description : Local 8-bit register port driven by the UART command
//                responder. The master side (responder) issues single-cycle
//                write/read strobes; the slave side (register file) returns
//                read data one cycle after the read strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_cmd_responder_if;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata;

  modport master (
    output reg_addr,
    output reg_wdata,
    output reg_wr,
    output reg_rd,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr,
    input  reg_wdata,
    input  reg_wr,
    input  reg_rd,
    output reg_rdata
  );
endinterface

`default_nettype wire

// File: rtl/uart_cmd_responder.sv
// ============================================================================
//  Module      : uart_cmd_responder
//  Description : Far-end responder for the 16-bit UART command initiator.
//                Receives {rw,addr[6:0]} + data byte frames on rx, performs a
//                single-cycle write or read on the local register port and,
//                for reads, returns the read byte on tx.
//                Optional feature macro: UART_RSP_PARITY_EN (even parity on
//                both rx and tx, 11-bit frames).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_responder #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BR           = 115200,
  parameter int TIMEOUT_BITS = 32
) (
  input  wire                  clk,
  input  wire                  rst,
  input  wire                  rx,
  output logic                 tx,
  output logic                 frame_err,
  output logic                 busy,
  uart_cmd_responder_if.master regs
);

  localparam int DIV       = CLK_FREQ / BR;
  localparam int HALF      = DIV / 2;
  localparam int CW        = $clog2(DIV);
  localparam int TO_CYCLES = TIMEOUT_BITS * DIV;
  localparam int TW        = $clog2(TO_CYCLES + 1);
`ifdef UART_RSP_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // tx shift register holds everything after the start bit
  localparam int SHW = FRAME_BITS - 1;

  localparam logic [CW-1:0] DIV_LAST    = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST   = CW'(HALF - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(TO_CYCLES - 1);
  localparam logic [3:0]    TX_LAST_BIT = 4'(FRAME_BITS - 1);

`ifdef UART_RSP_PARITY_EN
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
`else
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`endif
  typedef enum logic [1:0] {CMD_B0, CMD_B1, CMD_EXEC} cmd_state_t;
  typedef enum logic [0:0] {TX_IDLE, TX_SHIFT} tx_state_t;

  // ---------------------------------------------------------------- rx sync
  logic rx_meta, rx_sync, rx_prev;
  logic rx_fall;

  // Double-flop the asynchronous line, plus one stage for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  // ---------------------------------------------------------------- receiver
  rx_state_t     rx_state, rx_next;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rx_tick;   // current cycle is a sample point
  logic          rx_good;   // stop sampled good: rx_sh holds a valid byte
  logic          rx_bad;    // byte discarded (framing or parity)

  // Receiver state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  // Receiver next-state: first sample at mid start bit, then once per bit
  always_comb begin
    rx_next = rx_state;
    rx_tick = 1'b0;
    rx_good = 1'b0;
    rx_bad  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_fall) rx_next = RX_START;
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_tick = 1'b1;
          rx_next = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == DIV_LAST) begin
          rx_tick = 1'b1;
`ifdef UART_RSP_PARITY_EN
          if (rx_bit == 3'd7) rx_next = RX_PAR;
`else
          if (rx_bit == 3'd7) rx_next = RX_STOP;
`endif
        end
      end
`ifdef UART_RSP_PARITY_EN
      RX_PAR: begin
        if (rx_cnt == DIV_LAST) begin
          rx_tick = 1'b1;
          if (rx_sync != ^rx_sh) begin
            rx_bad  = 1'b1;
            rx_next = RX_IDLE;
          end else begin
            rx_next = RX_STOP;
          end
        end
      end
`endif
      RX_STOP: begin
        if (rx_cnt == DIV_LAST) begin
          rx_tick = 1'b1;
          rx_next = RX_IDLE;
          if (rx_sync) rx_good = 1'b1;
          else         rx_bad  = 1'b1;
        end
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  // Receiver baud counter, bit index and LSB-first shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else begin
      if (rx_state == RX_IDLE || rx_tick) rx_cnt <= '0;
      else                                rx_cnt <= rx_cnt + 1'b1;
      if (rx_state != RX_DATA) rx_bit <= '0;
      else if (rx_tick)        rx_bit <= rx_bit + 1'b1;
      if (rx_state == RX_DATA && rx_tick) rx_sh <= {rx_sync, rx_sh[7:1]};
    end
  end

  // ---------------------------------------------------------------- command
  cmd_state_t    cmd_state, cmd_next;
  logic          cmd_rw;
  logic [6:0]    cmd_addr;
  logic [TW-1:0] to_cnt;
  logic          timeout;
  logic          do_wr, do_rd, rd_drop;
  logic          rd_d1;       // cycle in which reg_rdata is valid
  logic          tx_active;
  tx_state_t     tx_state, tx_next;

  // A response is in flight from the read strobe until the stop bit ends
  assign tx_active = (tx_state != TX_IDLE) | rd_d1 | regs.reg_rd;

  // Command state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cmd_state <= CMD_B0;
    else     cmd_state <= cmd_next;
  end

  // Command next-state and execute decisions
  always_comb begin
    cmd_next = cmd_state;
    timeout  = 1'b0;
    do_wr    = 1'b0;
    do_rd    = 1'b0;
    rd_drop  = 1'b0;
    case (cmd_state)
      CMD_B0: begin
        if (rx_good) cmd_next = CMD_B1;
      end
      CMD_B1: begin
        if (rx_bad) begin
          cmd_next = CMD_B0;
        end else if (rx_good) begin
          cmd_next = CMD_EXEC;
          if (!cmd_rw)        do_wr   = 1'b1;
          else if (tx_active) rd_drop = 1'b1;
          else                do_rd   = 1'b1;
        end else if (rx_state == RX_IDLE && to_cnt == TO_LAST) begin
          timeout  = 1'b1;
          cmd_next = CMD_B0;
        end
      end
      CMD_EXEC: cmd_next = CMD_B0;
      default:  cmd_next = CMD_B0;
    endcase
  end

  // Command latches, register-port strobes and error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_rw         <= 1'b0;
      cmd_addr       <= '0;
      to_cnt         <= '0;
      regs.reg_addr  <= '0;
      regs.reg_wdata <= '0;
      regs.reg_wr    <= 1'b0;
      regs.reg_rd    <= 1'b0;
      rd_d1          <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      if (cmd_state == CMD_B0 && rx_good) {cmd_rw, cmd_addr} <= rx_sh;
      // idle time between bytes only; an rx frame in progress holds the count
      if (cmd_state != CMD_B1)      to_cnt <= '0;
      else if (rx_state == RX_IDLE) to_cnt <= to_cnt + 1'b1;
      regs.reg_wr <= do_wr;
      regs.reg_rd <= do_rd;
      if (do_wr) begin
        regs.reg_addr  <= cmd_addr;
        regs.reg_wdata <= rx_sh;
      end
      if (do_rd) regs.reg_addr <= cmd_addr;
      rd_d1     <= regs.reg_rd;
      frame_err <= rx_bad | timeout | rd_drop;
    end
  end

  // ---------------------------------------------------------------- transmitter
  logic [CW-1:0]  tx_cnt;
  logic [3:0]     tx_bit;
  logic [SHW-1:0] tx_sh;
  logic           tx_bit_end;

  assign tx_bit_end = (tx_state == TX_SHIFT) && (tx_cnt == DIV_LAST);

  // Transmitter state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_next;
  end

  // Transmitter next-state: leave only after the full stop-bit period
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (rd_d1) tx_next = TX_SHIFT;
      TX_SHIFT: if (tx_bit_end && tx_bit == TX_LAST_BIT) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // Transmitter datapath: read data captured and loaded with the start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx     <= 1'b1;
      tx_sh  <= '1;
      tx_cnt <= '0;
      tx_bit <= '0;
    end else if (tx_state == TX_IDLE) begin
      tx_cnt <= '0;
      tx_bit <= '0;
      if (rd_d1) begin
        tx <= 1'b0;
`ifdef UART_RSP_PARITY_EN
        tx_sh <= {1'b1, ^regs.reg_rdata, regs.reg_rdata};
`else
        tx_sh <= {1'b1, regs.reg_rdata};
`endif
      end else begin
        tx <= 1'b1;
      end
    end else if (tx_bit_end) begin
      tx_cnt <= '0;
      tx_bit <= tx_bit + 1'b1;
      tx     <= (tx_bit == TX_LAST_BIT) ? 1'b1 : tx_sh[0];
      tx_sh  <= {1'b1, tx_sh[SHW-1:1]};
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
    end
  end

  assign busy = (cmd_state != CMD_B0) | (rx_state != RX_IDLE) | tx_active;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_responder.sv
// ============================================================================
//  Module      : tb_uart_cmd_responder
//  Description : Self-checking bench for uart_cmd_responder. Drives UART
//                command frames, models the register file, decodes tx and
//                compares against a transaction-level expectation model.
//                Honours UART_RSP_PARITY_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_cmd_responder;

  localparam int CLK_FREQ = 1_152_000;
  localparam int BR       = 115200;
  localparam int DIV      = CLK_FREQ / BR;
`ifdef UART_RSP_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FRAME_BITS = PAR_EN ? 11 : 10;

  typedef struct {
    int         cyc;
    logic [6:0] addr;
    logic [7:0] data;
    logic       ok;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic tx, frame_err, busy;

  uart_cmd_responder_if regs_if();

  uart_cmd_responder #(
    .CLK_FREQ    (CLK_FREQ),
    .BR          (BR),
    .TIMEOUT_BITS(32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .tx       (tx),
    .frame_err(frame_err),
    .busy     (busy),
    .regs     (regs_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fe_cnt   = 0;
  int last_stop_cyc = 0;
  logic tx_last = 1'b1;
  logic [7:0] seed;
  logic [7:0] exp_mem [128];
  logic [7:0] regfile [128];
  bit         written [128];
  ev_t wr_q[$];
  ev_t rd_q[$];
  ev_t tx_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] init_val(input logic [6:0] a);
    return ({1'b0, a} * 8'd37) ^ seed;
  endfunction

  function automatic logic frame_ok(input logic [10:0] b);
    return (b[0] == 1'b0) && (b[FRAME_BITS-1] == 1'b1) && (!PAR_EN || b[9] == ^b[8:1]);
  endfunction

  // Register file on the slave side: read data valid one cycle after reg_rd
  always @(posedge clk) begin
    if (regs_if.reg_wr) begin
      regfile[regs_if.reg_addr] <= regs_if.reg_wdata;
      written[regs_if.reg_addr] <= 1'b1;
    end
    if (regs_if.reg_rd)
      regs_if.reg_rdata <= written[regs_if.reg_addr] ? regfile[regs_if.reg_addr]
                                                     : init_val(regs_if.reg_addr);
    else
      regs_if.reg_rdata <= 8'($urandom);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (regs_if.reg_wr) wr_q.push_back('{cyc, regs_if.reg_addr, regs_if.reg_wdata, 1'b1});
      if (regs_if.reg_rd) rd_q.push_back('{cyc, regs_if.reg_addr, 8'h00, 1'b1});
      if (frame_err) fe_cnt++;
    end
  end

  // tx decoder: mid-bit sampling from the detected start edge
  initial begin : tx_decoder
    logic [10:0] bits;
    int st;
    bit aborted;
    forever begin
      @(negedge clk);
      if (!rst && tx_last && !tx) begin
        st = cyc;
        aborted = 1'b0;
        bits = '1;
        for (int k = 0; k < FRAME_BITS; k++) begin
          repeat ((k == 0) ? DIV / 2 : DIV) @(negedge clk);
          if (rst) aborted = 1'b1;
          bits[k] = tx;
        end
        if (!aborted) tx_q.push_back('{st, 7'h00, bits[8:1], frame_ok(bits)});
      end
      tx_last = tx;
    end
  end

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: run exceeded cycle budget");
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_v, input bit par_bad);
    logic [10:0] fr;
    fr = PAR_EN ? {stop_v, (^b) ^ par_bad, b, 1'b0} : {1'b0, stop_v, b, 1'b0};
    for (int i = 0; i < FRAME_BITS; i++) begin
      if (i == FRAME_BITS - 1) last_stop_cyc = cyc;
      rx = fr[i];
      repeat (DIV) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * DIV) @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input bit rw, input logic [6:0] addr, input logic [7:0] data, input int gap);
    int wb, rb, tb, fe0, d;
    wb = wr_q.size(); rb = rd_q.size(); tb = tx_q.size(); fe0 = fe_cnt;
    send_byte({rw, addr}, 1'b1, 1'b0);
    idle_bits(gap);
    send_byte(data, 1'b1, 1'b0);
    idle_bits(rw ? FRAME_BITS + 3 : 2);
    check("cmd_frame_err", fe_cnt - fe0, 0);
    check("cmd_wr_count", wr_q.size() - wb, rw ? 0 : 1);
    check("cmd_rd_count", rd_q.size() - rb, rw ? 1 : 0);
    check("cmd_tx_count", tx_q.size() - tb, rw ? 1 : 0);
    check("cmd_reg_addr", regs_if.reg_addr, addr);
    if (!rw && wr_q.size() > wb) begin
      d = wr_q[wb].cyc - last_stop_cyc;
      check("wr_addr", wr_q[wb].addr, addr);
      check("wr_data", wr_q[wb].data, data);
      check("wr_timing", (d >= DIV / 2 && d <= DIV + 1), 1);
      check("reg_wdata_hold", regs_if.reg_wdata, data);
    end
    if (rw && rd_q.size() > rb && tx_q.size() > tb) begin
      d = rd_q[rb].cyc - last_stop_cyc;
      check("rd_addr", rd_q[rb].addr, addr);
      check("rd_timing", (d >= DIV / 2 && d <= DIV + 1), 1);
      check("tx_data", tx_q[tb].data, exp_mem[addr]);
      check("tx_frame", tx_q[tb].ok, 1);
      check("tx_latency", tx_q[tb].cyc - rd_q[rb].cyc, 2);
    end
    if (!rw) exp_mem[addr] = data;
  endtask

  initial begin : main
    int fe0, wb, rb, n;
    seed = 8'($urandom);
    for (int i = 0; i < 128; i++) exp_mem[i] = init_val(7'(i));

    // reset values
    repeat (5) @(posedge clk);
    #1;
    check("rst_tx", tx, 1);
    check("rst_reg_addr", regs_if.reg_addr, 0);
    check("rst_reg_wdata", regs_if.reg_wdata, 0);
    check("rst_reg_wr", regs_if.reg_wr, 0);
    check("rst_reg_rd", regs_if.reg_rd, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    idle_bits(2);

    // directed write and read
    run_cmd(1'b0, 7'h15, 8'hA5, 0);
    run_cmd(1'b0, 7'h03, 8'h3C, 1);
    run_cmd(1'b1, 7'h03, 8'h00, 0);

    // framing error on byte 0, then recovery
    fe0 = fe_cnt; wb = wr_q.size(); rb = rd_q.size();
    send_byte(8'h9A, 1'b0, 1'b0);
    idle_bits(2);
    check("framing_err_pulse", fe_cnt - fe0, 1);
    check("framing_no_wr", wr_q.size() - wb, 0);
    check("framing_no_rd", rd_q.size() - rb, 0);
    run_cmd(1'b0, 7'h01, 8'h55, 0);

    // inter-byte timeout, then recovery
    fe0 = fe_cnt; wb = wr_q.size();
    send_byte(8'h10, 1'b1, 1'b0);
    check("busy_partial", busy, 1);
    idle_bits(33);
    check("timeout_err_pulse", fe_cnt - fe0, 1);
    check("timeout_no_wr", wr_q.size() - wb, 0);
    check("timeout_busy", busy, 0);
    run_cmd(1'b0, 7'h22, 8'h77, 0);

    // short glitch on rx
    fe0 = fe_cnt; wb = wr_q.size(); rb = rd_q.size();
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    idle_bits(2);
    check("glitch_no_err", fe_cnt - fe0, 0);
    check("glitch_no_strobe", (wr_q.size() - wb) + (rd_q.size() - rb), 0);
    check("glitch_busy", busy, 0);

`ifdef UART_RSP_PARITY_EN
    // parity error on byte 1
    fe0 = fe_cnt; wb = wr_q.size();
    send_byte(8'h05, 1'b1, 1'b0);
    send_byte(8'h66, 1'b1, 1'b1);
    idle_bits(2);
    check("parity_err_pulse", fe_cnt - fe0, 1);
    check("parity_no_wr", wr_q.size() - wb, 0);
`endif

    // randomized commands
    for (int i = 0; i < 12; i++)
      run_cmd(1'(($urandom_range(0, 1))), 7'($urandom_range(0, 127)),
              8'($urandom), int'($urandom_range(0, 4)));

    // reset in the middle of an all-zero response
    run_cmd(1'b0, 7'h40, 8'h00, 0);
    send_byte(8'hC0, 1'b1, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0);
    n = 0;
    while (tx !== 1'b0 && n < 4 * DIV) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("resp_started", tx, 0);
    repeat (3 * DIV) @(posedge clk);
    #2;
    check("pre_rst_tx", tx, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_reg_addr", regs_if.reg_addr, 0);
    repeat (2 * DIV) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_bits(2);
    run_cmd(1'b1, 7'h15, 8'h00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
